// File: rtl/hilo_div_pkg.sv
// Shared constants for the HI/LO radix-2 restoring divider.
package hilo_div_pkg;

  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned COUNT_W  = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module hilo_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;

  assign shifted  = {rem, dvd_msb};
  // Non-negative trial result means the low W bits of the difference are the new remainder
  assign q_bit    = (shifted >= {1'b0, dvs});
  assign rem_next = q_bit ? (shifted[W-1:0] - dvs) : shifted[W-1:0];

endmodule

// File: rtl/hilo_div.sv
// Multi-cycle DIV/DIVU unit producing {HI=remainder, LO=quotient}.
// Optional HILO_DIV_ZERO_FAST_EN: divide-by-zero completes in one cycle.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int unsigned DIV_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [DIV_W-1:0]   dividend,
  input  logic [DIV_W-1:0]   divisor,
  input  logic               cancel,
  output logic               busy,
  output logic               result_valid,
  output logic [2*DIV_W-1:0] result
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(DIV_ITER - 1);

  logic [1:0]           state, state_d;
  logic [DIV_W-1:0]     rem, rem_d;
  logic [DIV_W-1:0]     dvd, dvd_d;
  logic [DIV_W-1:0]     dvs, dvs_d;
  logic [DIV_W-1:0]     quo, quo_d;
  logic [COUNT_W-1:0]   count, count_d;
  logic                 q_neg, q_neg_d;
  logic                 r_neg, r_neg_d;
  logic [2*DIV_W-1:0]   result_d;
  logic                 result_valid_d;
  logic [DIV_W-1:0]     step_rem;
  logic                 step_q;
  logic                 fast_zero;

`ifdef HILO_DIV_ZERO_FAST_EN
  assign fast_zero = (divisor == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // Stall in the start cycle itself so the pipeline never slips past an accepted divide
  assign busy = (state != ST_IDLE) | (start & ~cancel & ~rst);

  hilo_div_step #(.W(DIV_W)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[DIV_W-1]),
    .dvs      (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d        = state;
    rem_d          = rem;
    dvd_d          = dvd;
    dvs_d          = dvs;
    quo_d          = quo;
    count_d        = count;
    q_neg_d        = q_neg;
    r_neg_d        = r_neg;
    result_d       = result;
    result_valid_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (fast_zero) begin
            result_d       = {dividend, {DIV_W{1'b1}}};
            result_valid_d = 1'b1;
          end else begin
            dvd_d   = (signed_div && dividend[DIV_W-1]) ? (~dividend + DIV_W'(1)) : dividend;
            dvs_d   = (signed_div && divisor[DIV_W-1])  ? (~divisor + DIV_W'(1))  : divisor;
            q_neg_d = signed_div & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
            r_neg_d = signed_div & dividend[DIV_W-1];
            rem_d   = '0;
            quo_d   = '0;
            count_d = '0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        rem_d   = step_rem;
        dvd_d   = {dvd[DIV_W-2:0], 1'b0};
        quo_d   = {quo[DIV_W-2:0], step_q};
        count_d = count + COUNT_W'(1);
        if (count == LAST) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        result_d       = {(r_neg ? (~rem + DIV_W'(1)) : rem),
                          (q_neg ? (~quo + DIV_W'(1)) : quo)};
        result_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush aborts without touching the committed result
    if (cancel) begin
      state_d        = ST_IDLE;
      result_d       = result;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rem          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      quo          <= '0;
      count        <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_d;
      rem          <= rem_d;
      dvd          <= dvd_d;
      dvs          <= dvs_d;
      quo          <= quo_d;
      count        <= count_d;
      q_neg        <= q_neg_d;
      r_neg        <= r_neg_d;
      result       <= result_d;
      result_valid <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_hilo_div.sv
// Bench for hilo_div: behavioural timing/result model checked every cycle, plus directed literals.
module tb_hilo_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        result_valid;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  hilo_div #(.DIV_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

`ifdef HILO_DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics including the defined divide-by-zero outcome
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (FAST && b == 32'd0) return {a, 32'hFFFFFFFF};
    ua = (sd && a[31]) ? 32'd0 - a : a;
    ub = (sd && b[31]) ? 32'd0 - b : b;
    if (ub == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sd && (a[31] ^ b[31])) q = 32'd0 - q;
    if (sd && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int unsigned ref_lat(input logic [31:0] b);
    return (FAST && b == 32'd0) ? 1 : 34;
  endfunction

  // Cycle-level model: an accepted op completes a fixed number of cycles later
  bit          chk_en = 1'b0;
  int unsigned cyc = 0;
  bit          m_active = 1'b0;
  int unsigned m_done = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_held = '0;
  int          pulses = 0;

  always @(negedge clk) begin
    logic exp_valid, exp_busy;
    if (chk_en) begin
      exp_valid = 1'b0;
      if (m_active && cyc == m_done) begin
        m_held    = m_pend;
        exp_valid = 1'b1;
        m_active  = 1'b0;
      end
      exp_busy = m_active || (start && !cancel && !rst);
      if (!rst) check("busy", 64'(busy), 64'(exp_busy));
      check("result_valid", 64'(result_valid), 64'(exp_valid));
      check("result", result, m_held);
      if (result_valid) pulses++;
      if (rst) begin
        m_active = 1'b0;
        m_held   = '0;
      end else if (cancel) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_done   = cyc + ref_lat(divisor);
        m_pend   = ref_div(signed_div, dividend, divisor);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle and wait (bounded) for its completion pulse
  task automatic run_op(input string name, input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] want, input int unsigned want_lat);
    int unsigned n;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!result_valid && n < 60) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(want_lat));
    check({name, "_value"}, result, want);
  endtask

  initial begin
    int unsigned n;
    logic [63:0] saved;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_result", result, 64'h0);
    check("reset_valid", 64'(result_valid), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 34);
    run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
    run_op("divu_zero", 1'b0, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF, FAST ? 1 : 34);
    run_op("div_m5_zero", 1'b1, 32'hFFFFFFFB, 32'h0,
           FAST ? 64'hFFFFFFFB_FFFFFFFF : 64'hFFFFFFFB_00000001, FAST ? 1 : 34);
    tick();

    // Cancel mid-operation, then restart right away
    saved = result;
    signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'h0);
    check("cancel_result_kept", result, saved);
    run_op("after_cancel", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 34);

    // Second start while busy is dropped
    signed_div = 1'b0; dividend = 32'd77; divisor = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    dividend = 32'd999; divisor = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n = 6;
    while (!result_valid && n < 60) begin
      tick();
      n++;
    end
    check("repulse_latency", 64'(n), 64'd34);
    check("repulse_value", result, 64'h00000007_00000007);

    // Reset mid-operation clears the committed result
    tick();
    signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_result", result, 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_valid", 64'(result_valid), 64'h0);

    // Randomized traffic; the per-cycle model does the checking
    pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      cancel     = ($urandom_range(0, 59) == 0);
      signed_div = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 7))
          0:       v = 32'h0;
          1:       v = 32'h80000000;
          2:       v = 32'hFFFFFFFF;
          3:       v = 32'($urandom_range(1, 15));
          default: v = $urandom;
        endcase
        if (k == 0) dividend = v; else divisor = v;
      end
      tick();
    end
    start = 1'b0; cancel = 1'b0;
    repeat (40) tick();
    checks++;
    if (pulses < 5) begin
      errors++;
      $display("FAIL random_pulses got %0d want >=5", pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
